// File: rtl/sipm_readout_scheduler.sv
// Round-robin readout scheduler for an array of single-SiPM reader channels.
// Grants one pending channel at a time, emits {channel, timestamp, height} on a
// valid/ready stream, then pulses that channel's clear and re-arms it.
// Ports: clk, rst_n (async active-low), enable, ch_mask, force_clear,
//   ch_timestamp/ch_height (packed, ch0 in LSBs), ch_clear, out_valid,
//   out_ready, out_channel, out_timestamp, out_height, busy.
// Optional: define SIPM_SCHED_EVENT_COUNT_EN to add a saturating 32-bit
//   event_count output (accepted words).
module sipm_readout_scheduler #(
  parameter int N_CH          = 4,
  parameter int TIMESTAMP_LEN = 40,
  parameter int CLEAR_CYCLES  = 2,
  localparam int CH_W         = $clog2(N_CH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [N_CH-1:0]               ch_mask,
  input  logic                          force_clear,
  input  logic [N_CH*TIMESTAMP_LEN-1:0] ch_timestamp,
  input  logic [N_CH*2-1:0]             ch_height,
  output logic [N_CH-1:0]               ch_clear,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CH_W-1:0]               out_channel,
  output logic [TIMESTAMP_LEN-1:0]      out_timestamp,
  output logic [1:0]                    out_height,
  output logic                          busy
`ifdef SIPM_SCHED_EVENT_COUNT_EN
  ,
  output logic [31:0]                   event_count
`endif
);

  localparam int CNT_W = $clog2(CLEAR_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_EMIT,
    S_CLEAR_ONE,
    S_CLEAR_ALL,
    S_SETTLE
  } state_t;

  state_t state, state_n;

  logic [CNT_W-1:0]         cnt;
  logic                     cnt_last;
  logic [CH_W-1:0]          rr_ptr;
  logic [N_CH-1:0]          pending;
  logic [CH_W-1:0]          pick;
  logic                     found;
  logic [CH_W:0]            sum;

  logic [TIMESTAMP_LEN-1:0] ts_arr [N_CH];
  logic [1:0]               ht_arr [N_CH];

  for (genvar g = 0; g < N_CH; g++) begin : g_unpack
    assign ts_arr[g] = ch_timestamp[g*TIMESTAMP_LEN +: TIMESTAMP_LEN];
    assign ht_arr[g] = ch_height[g*2 +: 2];
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < N_CH; i++) begin
      pending[i] = (ht_arr[i] != 2'b00) & ~ch_mask[i];
    end
  end

  // First pending index at or after rr_ptr, wrapping modulo N_CH.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    for (int k = 0; k < N_CH; k++) begin
      sum = {1'b0, rr_ptr} + (CH_W+1)'(k);
      if (sum >= (CH_W+1)'(N_CH)) begin
        sum = sum - (CH_W+1)'(N_CH);
      end
      if (!found && pending[sum[CH_W-1:0]]) begin
        found = 1'b1;
        pick  = sum[CH_W-1:0];
      end
    end
  end

  assign cnt_last = (cnt == CNT_W'(CLEAR_CYCLES - 1));

  always_comb begin
    state_n = state;
    unique case (state)
      S_INIT,
      S_CLEAR_ALL,
      S_CLEAR_ONE: if (cnt_last) state_n = S_SETTLE;
      S_IDLE: begin
        if (force_clear) begin
          state_n = S_CLEAR_ALL;
        end else if (enable && found) begin
          state_n = S_EMIT;
        end
      end
      S_EMIT:   if (out_ready) state_n = S_CLEAR_ONE;
      S_SETTLE: state_n = force_clear ? S_CLEAR_ALL : S_IDLE;
      default:  state_n = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INIT;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (state_n != state) begin
        cnt <= '0;
      end else if (!cnt_last) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_channel   <= '0;
      out_timestamp <= '0;
      out_height    <= '0;
      rr_ptr        <= '0;
    end else begin
      if (state == S_IDLE && state_n == S_EMIT) begin
        out_channel   <= pick;
        out_timestamp <= ts_arr[pick];
        out_height    <= ht_arr[pick];
      end
      if (state == S_EMIT && out_ready) begin
        rr_ptr <= (out_channel == CH_W'(N_CH - 1)) ? '0
                : out_channel + CH_W'(1);
      end
    end
  end

  always_comb begin
    ch_clear = '0;
    unique case (state)
      S_INIT,
      S_CLEAR_ALL: ch_clear = '1;
      S_CLEAR_ONE: ch_clear[out_channel] = 1'b1;
      default:     ch_clear = '0;
    endcase
  end

  assign out_valid = (state == S_EMIT);
  assign busy      = (state != S_IDLE);

`ifdef SIPM_SCHED_EVENT_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      event_count <= '0;
    end else if (out_valid && out_ready && event_count != 32'hFFFF_FFFF) begin
      event_count <= event_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sipm_readout_scheduler.sv
// Directed self-checking bench for sipm_readout_scheduler.
// Samples outputs on the falling edge; drives inputs right after sampling.
module tb_sipm_readout_scheduler;

  localparam int N_CH = 4;
  localparam int TL   = 40;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic [N_CH-1:0]   ch_mask;
  logic              force_clear;
  logic [N_CH*TL-1:0] ch_timestamp;
  logic [N_CH*2-1:0] ch_height;
  logic [N_CH-1:0]   ch_clear;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_channel;
  logic [TL-1:0]     out_timestamp;
  logic [1:0]        out_height;
  logic              busy;
`ifdef SIPM_SCHED_EVENT_COUNT_EN
  logic [31:0]       event_count;
`endif

  int checks = 0;
  int errors = 0;

  sipm_readout_scheduler #(
    .N_CH(N_CH),
    .TIMESTAMP_LEN(TL),
    .CLEAR_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .ch_mask(ch_mask),
    .force_clear(force_clear),
    .ch_timestamp(ch_timestamp),
    .ch_height(ch_height),
    .ch_clear(ch_clear),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_channel(out_channel),
    .out_timestamp(out_timestamp),
    .out_height(out_height),
    .busy(busy)
`ifdef SIPM_SCHED_EVENT_COUNT_EN
    ,
    .event_count(event_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    enable = 1'b0;
    ch_mask = '0;
    force_clear = 1'b0;
    ch_timestamp = '0;
    ch_height = '0;
    out_ready = 1'b0;
    #3;
    checks++;
    if (ch_clear !== 4'b1111 || out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: clear=%b valid=%b busy=%b want 1111 0 1",
               ch_clear, out_valid, busy);
    end
    checks++;
    if (out_channel !== 2'd0 || out_timestamp !== 40'd0 || out_height !== 2'd0) begin
      errors++;
      $display("FAIL reset_fields: ch=%0d ts=%h h=%b want 0 0 00",
               out_channel, out_timestamp, out_height);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ch_clear !== 4'b1111) begin
      errors++;
      $display("FAIL init_clear_c1: got %b want 1111", ch_clear);
    end
    @(negedge clk);
    checks++;
    if (ch_clear !== 4'b0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL init_settle: clear=%b busy=%b want 0000 1", ch_clear, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL init_idle: busy=%b valid=%b want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_single;
    enable = 1'b1;
    out_ready = 1'b1;
    ch_timestamp[2*TL +: TL] = 40'h00000000A5;
    ch_height[5:4] = 2'b10;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_channel !== 2'd2 ||
        out_timestamp !== 40'h00000000A5 || out_height !== 2'b10) begin
      errors++;
      $display("FAIL single_word: v=%b ch=%0d ts=%h h=%b want 1 2 a5 10",
               out_valid, out_channel, out_timestamp, out_height);
    end
    ch_height[5:4] = 2'b00;
    @(negedge clk);
    checks++;
    if (ch_clear !== 4'b0100 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_clear1: clear=%b valid=%b want 0100 0", ch_clear, out_valid);
    end
    @(negedge clk);
    checks++;
    if (ch_clear !== 4'b0100) begin
      errors++;
      $display("FAIL single_clear2: got %b want 0100", ch_clear);
    end
    @(negedge clk);
    checks++;
    if (ch_clear !== 4'b0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_settle: clear=%b busy=%b want 0000 1", ch_clear, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_round_robin;
    int exp_ch[3] = '{3, 0, 1};
    logic [39:0] exp_ts[3] = '{40'h33, 40'h11, 40'h22};
    logic [1:0] exp_h[3] = '{2'b10, 2'b01, 2'b11};
    logic [3:0] onehot;
    bit ok;
    ch_timestamp[0*TL +: TL] = 40'h11;
    ch_timestamp[1*TL +: TL] = 40'h22;
    ch_timestamp[3*TL +: TL] = 40'h33;
    ch_height = 8'b10_00_11_01;
    for (int j = 0; j < 3; j++) begin
      wait_valid(10, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rr_timeout_%0d: no out_valid, want ch %0d", j, exp_ch[j]);
      end
      checks++;
      if (out_channel !== 2'(exp_ch[j]) || out_timestamp !== exp_ts[j] ||
          out_height !== exp_h[j]) begin
        errors++;
        $display("FAIL rr_word_%0d: ch=%0d ts=%h h=%b want %0d %h %b", j,
                 out_channel, out_timestamp, out_height,
                 exp_ch[j], exp_ts[j], exp_h[j]);
      end
      ch_height[2*exp_ch[j] +: 2] = 2'b00;
      onehot = 4'b0001 << exp_ch[j];
      @(negedge clk);
      checks++;
      if (ch_clear !== onehot) begin
        errors++;
        $display("FAIL rr_clear_%0d: got %b want %b", j, ch_clear, onehot);
      end
    end
    wait_idle(10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rr_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_backpressure_force;
    bit ok;
    out_ready = 1'b0;
    ch_timestamp[2*TL +: TL] = 40'h123456789A;
    ch_height[5:4] = 2'b01;
    wait_valid(10, ok);
    checks++;
    if (!ok || out_channel !== 2'd2) begin
      errors++;
      $display("FAIL bp_grant: ok=%b ch=%0d want 1 2", ok, out_channel);
    end
    for (int i = 0; i < 10; i++) begin
      force_clear = (i % 3 == 0);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_channel !== 2'd2 ||
          out_timestamp !== 40'h123456789A || out_height !== 2'b01 ||
          ch_clear !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold_%0d: v=%b ch=%0d ts=%h h=%b clr=%b", i,
                 out_valid, out_channel, out_timestamp, out_height, ch_clear);
      end
    end
    force_clear = 1'b1;
    out_ready = 1'b1;
    ch_height[5:4] = 2'b00;
    @(negedge clk);
    checks++;
    if (ch_clear !== 4'b0100 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_clear_one: clr=%b v=%b want 0100 0", ch_clear, out_valid);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ch_clear !== 4'b0000) begin
      errors++;
      $display("FAIL bp_settle: clr=%b want 0000", ch_clear);
    end
    @(negedge clk);
    checks++;
    if (ch_clear !== 4'b1111 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_clear_all: clr=%b busy=%b want 1111 1", ch_clear, busy);
    end
    force_clear = 1'b0;
    wait_idle(10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_mask_enable;
    bit ok;
    enable = 1'b0;
    ch_mask = 4'b0010;
    ch_height = 8'b00_00_11_01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || ch_clear !== 4'b0000) begin
        errors++;
        $display("FAIL en_off_%0d: v=%b busy=%b clr=%b want 0 0 0000",
                 i, out_valid, busy, ch_clear);
      end
    end
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_channel !== 2'd0 || out_height !== 2'b01) begin
      errors++;
      $display("FAIL mask_grant: v=%b ch=%0d h=%b want 1 0 01",
               out_valid, out_channel, out_height);
    end
    ch_height[1:0] = 2'b00;
    @(negedge clk);
    checks++;
    if (ch_clear !== 4'b0001) begin
      errors++;
      $display("FAIL mask_clear: got %b want 0001", ch_clear);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || ch_clear[1] !== 1'b0) begin
        errors++;
        $display("FAIL mask_ch1_%0d: v=%b clr=%b want 0 x0xx",
                 i, out_valid, ch_clear);
      end
    end
    ch_mask = '0;
    ch_height = '0;
    wait_idle(10, ok);
  endtask

  task automatic test_reset_mid_emit;
    bit ok;
    out_ready = 1'b0;
    ch_timestamp[3*TL +: TL] = 40'h77;
    ch_height[7:6] = 2'b10;
    wait_valid(10, ok);
    checks++;
    if (!ok || out_channel !== 2'd3) begin
      errors++;
      $display("FAIL rst_grant: ok=%b ch=%0d want 1 3", ok, out_channel);
    end
`ifdef SIPM_SCHED_EVENT_COUNT_EN
    checks++;
    if (event_count !== 32'd6) begin
      errors++;
      $display("FAIL evcnt_pre: got %0d want 6", event_count);
    end
`endif
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || ch_clear !== 4'b1111 || out_timestamp !== 40'd0) begin
      errors++;
      $display("FAIL rst_async: v=%b clr=%b ts=%h want 0 1111 0",
               out_valid, ch_clear, out_timestamp);
    end
`ifdef SIPM_SCHED_EVENT_COUNT_EN
    checks++;
    if (event_count !== 32'd0) begin
      errors++;
      $display("FAIL evcnt_post: got %0d want 0", event_count);
    end
`endif
    ch_height = '0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_idle(10, ok);
    checks++;
    if (!ok || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_recover: ok=%b v=%b want 1 0", ok, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure_force();
    test_mask_enable();
    test_reset_mid_emit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
